// File: rtl/dii_package.sv
// Debug-ring flit type shared by DII endpoints.
//   dii_flit.data  : 16-bit word carried by the flit
//   dii_flit.last  : marks the final word of a packet
//   dii_flit.valid : flit holds a word this cycle
package dii_package;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;

endpackage

// File: rtl/osd_trace_depacketization.sv
// Trace depacketizer: parses DII event packets addressed to this module and
// reassembles the payload into one trace sample or one overflow record.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous reset, active low
//   id             : own DII address, compared against the destination word
//   debug_in       : incoming flits (data, last, valid)
//   debug_in_ready : flit accepted when debug_in.valid && debug_in_ready
//   trace_data     : reassembled sample, or lost count for overflow records
//   trace_overflow : current record is an overflow record
//   trace_src      : source word of the packet that produced the record
//   trace_valid    : a record is being presented
//   trace_ready    : consumer takes the record
//   err            : one-cycle pulse after a malformed packet
//
// state   | meaning
// --------+--------------------------------------------------------------
// DEST    | waiting for the destination word
// SRC     | waiting for the source word
// HDR     | waiting for the event header
// PAYLOAD | collecting payload words, least-significant first
// DROP    | discarding flits up to and including the next last
// OUT     | presenting the record, ring is back-pressured
module osd_trace_depacketization
  import dii_package::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      id,
  input  dii_flit          debug_in,
  output logic             debug_in_ready,
  output logic [WIDTH-1:0] trace_data,
  output logic             trace_overflow,
  output logic [15:0]      trace_src,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic             err
);

  localparam int NW   = (WIDTH + 15) / 16;
  localparam int IDXW = $clog2(NW + 1);

  typedef enum logic [2:0] {
    ST_DEST,
    ST_SRC,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP,
    ST_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      src_q, src_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  exp_q, exp_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             accept;
  logic             wr_payload;
  logic             clr_upper;
  logic [IDXW-1:0]  idx_inc;
  logic [1:0]       hdr_type;
  logic [3:0]       hdr_sub;

  assign accept   = debug_in.valid && (state_q != ST_OUT);
  assign idx_inc  = idx_q + IDXW'(1);
  assign hdr_type = debug_in.data[15:14];
  assign hdr_sub  = debug_in.data[13:10];

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    idx_d      = idx_q;
    exp_d      = exp_q;
    ovf_d      = ovf_q;
    err_d      = 1'b0;
    wr_payload = 1'b0;
    clr_upper  = 1'b0;

    case (state_q)
      ST_DEST: begin
        if (accept) begin
          if (debug_in.last) begin
            err_d = 1'b1;
          end else if (debug_in.data == id) begin
            state_d = ST_SRC;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_SRC: begin
        if (accept) begin
          src_d = debug_in.data;
          if (debug_in.last) begin
            err_d   = 1'b1;
            state_d = ST_DEST;
          end else begin
            state_d = ST_HDR;
          end
        end
      end

      ST_HDR: begin
        if (accept) begin
          idx_d = '0;
          if (debug_in.last) begin
            err_d   = 1'b1;
            state_d = ST_DEST;
          end else if (hdr_type != 2'b10) begin
            // Non-event traffic is not ours to complain about.
            state_d = ST_DROP;
          end else if (hdr_sub == 4'd0) begin
            exp_d   = IDXW'(NW);
            ovf_d   = 1'b0;
            state_d = ST_PAYLOAD;
          end else if (hdr_sub == 4'd1) begin
            exp_d   = IDXW'(1);
            ovf_d   = 1'b1;
            state_d = ST_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DROP;
          end
        end
      end

      ST_PAYLOAD: begin
        if (accept) begin
          wr_payload = 1'b1;
          idx_d      = idx_inc;
          if (idx_inc == exp_q) begin
            if (debug_in.last) begin
              state_d   = ST_OUT;
              clr_upper = ovf_q;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DROP;
            end
          end else if (debug_in.last) begin
            err_d   = 1'b1;
            state_d = ST_DEST;
          end
        end
      end

      ST_DROP: begin
        if (accept && debug_in.last) begin
          state_d = ST_DEST;
        end
      end

      ST_OUT: begin
        if (trace_ready) begin
          state_d = ST_DEST;
        end
      end

      default: state_d = ST_DEST;
    endcase
  end

  // Per-bit assembly update: bit i belongs to payload word i/16. Bits of the
  // last word beyond WIDTH have no home and are simply never stored. Overflow
  // records only carry word 0, so everything above it is zeroed on entry to OUT.
  for (genvar i = 0; i < WIDTH; i++) begin : g_asm
    localparam int WORD = i / 16;
    assign asm_d[i] = (clr_upper && (i >= 16)) ? 1'b0 :
                      (wr_payload && (idx_q == IDXW'(WORD))) ? debug_in.data[i % 16] :
                      asm_q[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_DEST;
      src_q   <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
      exp_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign debug_in_ready = (state_q != ST_OUT);
  assign trace_valid    = (state_q == ST_OUT);
  assign trace_data     = asm_q;
  assign trace_overflow = ovf_q;
  assign trace_src      = src_q;
  assign err            = err_q;

endmodule

// File: tb/tb_osd_trace_depacketization.sv
// Self-checking bench for osd_trace_depacketization (WIDTH = 40, id = 0x0005).
// A packet-level model decides what each packet must produce (record or not,
// error or not); a compare process checks records and invariants every cycle.
module tb_osd_trace_depacketization;
  import dii_package::*;

  localparam int          WIDTH = 40;
  localparam int          NW    = 3;
  localparam logic [15:0] ID    = 16'h0005;

  typedef logic [15:0] pkt_t [8];
  typedef struct {
    logic [39:0] data;
    logic        ovf;
    logic [15:0] src;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst;
  dii_flit          debug_in;
  logic             debug_in_ready;
  logic [WIDTH-1:0] trace_data;
  logic             trace_overflow;
  logic [15:0]      trace_src;
  logic             trace_valid;
  logic             trace_ready;
  logic             err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_seen = 0;
  rec_t exp_q[$];
  rec_t exp_rec;
  rec_t last_got;
  bit          hold_q = 1'b0;
  logic [39:0] hold_data;
  logic        hold_ovf;
  logic [15:0] hold_src;

  osd_trace_depacketization #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .id            (ID),
    .debug_in      (debug_in),
    .debug_in_ready(debug_in_ready),
    .trace_data    (trace_data),
    .trace_overflow(trace_overflow),
    .trace_src     (trace_src),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Packet-level reference: what a whole packet must produce.
  function automatic void model(input pkt_t p, input int len, output bit has, output rec_t r,
                                output int ne, output int eidx);
    logic [15:0] hdr;
    logic [47:0] acc;
    int n;
    has = 1'b0; ne = 0; eidx = -1;
    r.data = '0; r.ovf = 1'b0; r.src = '0;
    if (len < 2) begin ne = 1; eidx = 0; return; end
    if (p[0] != ID) return;
    if (len < 4) begin ne = 1; eidx = len - 1; return; end
    hdr = p[2];
    if (hdr[15:14] != 2'b10) return;
    if (hdr[13:10] == 4'd0) n = NW;
    else if (hdr[13:10] == 4'd1) n = 1;
    else begin ne = 1; eidx = 2; return; end
    if (len - 3 < n) begin ne = 1; eidx = len - 1; return; end
    if (len - 3 > n) begin ne = 1; eidx = 2 + n; return; end
    has   = 1'b1;
    r.src = p[1];
    r.ovf = (hdr[13:10] == 4'd1);
    acc   = '0;
    for (int k = 0; k < n; k++) acc = acc | ({32'h0, p[3 + k]} << (16 * k));
    r.data = acc[39:0];
  endfunction

  // Compare process: records, stability under backpressure, ready/valid relation.
  always @(negedge clk) begin
    if (!rst) begin
      hold_q = 1'b0;
    end else begin
      chk("ready_is_not_valid", debug_in_ready, !trace_valid);
      if (hold_q) begin
        chk("held_valid", trace_valid, 1'b1);
        chk("held_data", trace_data, hold_data);
        chk("held_ovf", trace_overflow, hold_ovf);
        chk("held_src", trace_src, hold_src);
      end
      if (trace_valid && trace_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_record: got data %0h src %0h, expected no record", trace_data, trace_src);
        end else begin
          exp_rec = exp_q.pop_front();
          chk("rec_data", trace_data, exp_rec.data);
          chk("rec_ovf", trace_overflow, exp_rec.ovf);
          chk("rec_src", trace_src, exp_rec.src);
        end
        last_got = '{trace_data, trace_overflow, trace_src};
      end
      if (err) err_seen++;
      hold_q    = trace_valid && !trace_ready;
      hold_data = trace_data;
      hold_ovf  = trace_overflow;
      hold_src  = trace_src;
    end
  end

  // Called and returns at posedge+1.
  task automatic send_pkt(input pkt_t p, input int len, input int gap, input bit mark_last,
                          output int waits);
    int budget;
    waits = 0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          debug_in.valid = 1'b0;
          debug_in.data  = 16'hFFFF;
          debug_in.last  = 1'b1;
          @(posedge clk); #1;
        end
      end
      debug_in.valid = 1'b1;
      debug_in.data  = p[i];
      debug_in.last  = mark_last && (i == len - 1);
      budget = 0;
      forever begin
        @(negedge clk);
        if (debug_in_ready) begin
          @(posedge clk);
          break;
        end
        @(posedge clk);
        if (i == 0) waits++;
        budget++;
        if (budget > 50) begin
          n_checks++;
          n_fail++;
          $display("FAIL flit_accept_timeout: got no ready in %0d cycles, expected ready", budget);
          break;
        end
      end
      #1;
    end
    debug_in.valid = 1'b0;
    debug_in.last  = 1'b0;
  endtask

  task automatic settle(input string name, input int e0, input int ne);
    repeat (3) @(negedge clk);
    chk({name, "_err_count"}, err_seen - e0, ne);
    chk({name, "_records_drained"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_pkt(input string name, input pkt_t p, input int len, input int gap);
    bit   has;
    rec_t r;
    int   ne, eidx, e0, w;
    model(p, len, has, r, ne, eidx);
    if (has) exp_q.push_back(r);
    e0 = err_seen;
    send_pkt(p, len, gap, 1'b1, w);
    @(negedge clk);
    chk({name, "_valid_latency"}, trace_valid, has);
    chk({name, "_err_timing"}, err, (ne != 0) && (eidx == len - 1));
    settle(name, e0, ne);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_valid"}, trace_valid, 1'b0);
    chk({name, "_ovf"}, trace_overflow, 1'b0);
    chk({name, "_data"}, trace_data, 40'h0);
    chk({name, "_src"}, trace_src, 16'h0);
    chk({name, "_err"}, err, 1'b0);
    chk({name, "_ready"}, debug_in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   has;
    rec_t r;
    int   ne, eidx, e0, w;

    rst         = 1'b0;
    trace_ready = 1'b1;
    debug_in    = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset("after_reset");
    @(posedge clk); #1;

    // Model pins against hand-computed values.
    model('{16'h0005, 16'h0010, 16'h8000, 16'hAAAA, 16'hBBBB, 16'h00CC, 16'h0, 16'h0}, 6, has, r, ne, eidx);
    chk("model_pin_sample", r.data, 40'hCC_BBBB_AAAA);
    chk("model_pin_sample_err", ne, 0);
    model('{16'h0005, 16'h0010, 16'h8000, 16'hAAAA, 16'h0, 16'h0, 16'h0, 16'h0}, 4, has, r, ne, eidx);
    chk("model_pin_short_err", ne, 1);

    run_pkt("sample", '{16'h0005, 16'h0010, 16'h8000, 16'hAAAA, 16'hBBBB, 16'h00CC, 16'h0, 16'h0}, 6, 0);
    chk("sample_lit_data", last_got.data, 40'hCC_BBBB_AAAA);
    chk("sample_lit_src", last_got.src, 16'h0010);
    chk("sample_lit_ovf", last_got.ovf, 1'b0);

    run_pkt("overflow", '{16'h0005, 16'h0010, 16'h8400, 16'h0007, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 0);
    chk("overflow_lit_data", last_got.data, 40'h7);
    chk("overflow_lit_ovf", last_got.ovf, 1'b1);

    // Foreign destination followed back-to-back by a good packet.
    model('{16'h0006, 16'h0010, 16'h8000, 16'h1111, 16'h2222, 16'h0033, 16'h0, 16'h0}, 6, has, r, ne, eidx);
    if (has) exp_q.push_back(r);
    model('{16'h0005, 16'h0033, 16'h8000, 16'h1234, 16'h5678, 16'h009A, 16'h0, 16'h0}, 6, has, r, ne, eidx);
    if (has) exp_q.push_back(r);
    e0 = err_seen;
    send_pkt('{16'h0006, 16'h0010, 16'h8000, 16'h1111, 16'h2222, 16'h0033, 16'h0, 16'h0}, 6, 0, 1'b1, w);
    send_pkt('{16'h0005, 16'h0033, 16'h8000, 16'h1234, 16'h5678, 16'h009A, 16'h0, 16'h0}, 6, 0, 1'b1, w);
    @(negedge clk);
    chk("b2b_valid_latency", trace_valid, 1'b1);
    settle("b2b", e0, 0);
    chk("b2b_lit_data", last_got.data, 40'h9A_5678_1234);
    chk("b2b_lit_src", last_got.src, 16'h0033);

    run_pkt("short", '{16'h0005, 16'h0010, 16'h8000, 16'hAAAA, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 0);
    run_pkt("long", '{16'h0005, 16'h0010, 16'h8000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0}, 7, 0);
    run_pkt("ovf_long", '{16'h0005, 16'h0010, 16'h8400, 16'h0007, 16'h0008, 16'h0, 16'h0, 16'h0}, 5, 0);
    run_pkt("non_event", '{16'h0005, 16'h0010, 16'h4000, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0}, 6, 0);
    run_pkt("bad_subtype", '{16'h0005, 16'h0010, 16'h8800, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 0);
    run_pkt("dest_last", '{16'h0005, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1, 0);
    run_pkt("src_last", '{16'h0005, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 2, 0);
    run_pkt("hdr_last", '{16'h0005, 16'h0010, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 3, 0);
    run_pkt("bubbles", '{16'h0005, 16'h0044, 16'h8000, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0}, 6, 2);
    chk("bubbles_lit_data", last_got.data, 40'h03_0002_0001);

    // Backpressure: consumer stalls for 10 cycles.
    trace_ready = 1'b0;
    model('{16'h0005, 16'h0077, 16'h8000, 16'hDEAD, 16'hBEEF, 16'h0012, 16'h0, 16'h0}, 6, has, r, ne, eidx);
    if (has) exp_q.push_back(r);
    e0 = err_seen;
    send_pkt('{16'h0005, 16'h0077, 16'h8000, 16'hDEAD, 16'hBEEF, 16'h0012, 16'h0, 16'h0}, 6, 0, 1'b1, w);
    @(negedge clk);
    chk("bp_valid_latency", trace_valid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_ready_low", debug_in_ready, 1'b0);
      chk("bp_valid_high", trace_valid, 1'b1);
      chk("bp_data_lit", trace_data, 40'h12_BEEF_DEAD);
    end
    @(posedge clk); #1;
    trace_ready = 1'b1;
    model('{16'h0005, 16'h0078, 16'h8400, 16'h0042, 16'h0, 16'h0, 16'h0, 16'h0}, 4, has, r, ne, eidx);
    if (has) exp_q.push_back(r);
    send_pkt('{16'h0005, 16'h0078, 16'h8400, 16'h0042, 16'h0, 16'h0, 16'h0, 16'h0}, 4, 0, 1'b1, w);
    chk("bp_release_wait_cycles", w, 1);
    @(negedge clk);
    chk("bp_next_valid_latency", trace_valid, 1'b1);
    settle("bp", e0, 0);
    chk("bp_next_lit_data", last_got.data, 40'h42);

    // Leave a sample in the output register, then reset mid-packet.
    run_pkt("pre_reset", '{16'h0005, 16'h0099, 16'h8000, 16'h0101, 16'h0202, 16'h0303, 16'h0, 16'h0}, 6, 0);
    send_pkt('{16'h0005, 16'h0088, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 3, 0, 1'b0, w);
    rst = 1'b0;
    #1;
    check_reset("mid_reset");
    @(negedge clk);
    check_reset("mid_reset_held");
    rst = 1'b1;
    @(posedge clk); #1;
    run_pkt("post_reset", '{16'h0005, 16'h00AB, 16'h8000, 16'hCAFE, 16'hF00D, 16'h0055, 16'h0, 16'h0}, 6, 0);
    chk("post_reset_lit_data", last_got.data, 40'h55_F00D_CAFE);
    chk("post_reset_lit_src", last_got.src, 16'h00AB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_trace_depacketization.md
# osd_trace_depacketization

Receive-side counterpart of the trace packetizer. Consumes DII event packets addressed to this module, strips the header, and reassembles the 16-bit payload words into one WIDTH-bit trace sample or one overflow record, presented on a valid/ready output. It sits behind a debug-ring endpoint in host-side or on-chip trace sinks, for example trace compressors and loopback test harnesses.

## Interface
- WIDTH, default 16: trace sample width in bits. Payload word count NW = ceil(WIDTH/16), at least 1.
- clk  in  1: clock; all logic on rising edge.
- rst  in  1: reset, asynchronous, active-low.
- id  in  16: own DII address; compared against the destination word.
- debug_in  in  dii_flit: incoming flits with fields data[15:0], valid, last.
- debug_in_ready  out  1: flit is accepted when debug_in.valid && debug_in_ready.
- trace_data  out  WIDTH: reassembled sample; for overflow records, [15:0] = lost count and all other bits 0.
- trace_overflow  out  1: current output is an overflow record.
- trace_src  out  16: source word of the packet that produced the output.
- trace_valid  out  1: output holds a record.
- trace_ready  in  1: consumer accepts the record.
- err  out  1: one-cycle pulse on a malformed packet.

## Operation
- Packet format is one word per flit:
  - Word 0: destination.
  - Word 1: source.
  - Word 2: header. [15:14] = type; 2'b10 = EVENT. [13:10] = subtype; 0 = sample, 1 = overflow. [9:0] are ignored.
  - Words 3 onward: payload, least-significant word first.
- States are DEST, SRC, HDR, PAYLOAD, DROP and OUT. Reset state is DEST.
- DEST, on an accepted flit:
  - If data == id and !last, go to SRC.
  - If data != id and !last, go to DROP.
  - If last, stay in DEST and pulse err (packet too short).
- SRC, on an accepted flit: latch src. If last, pulse err and go to DEST. Otherwise go to HDR.
- HDR, on an accepted flit:
  - If last, pulse err and go to DEST.
  - If type != 2'b10, go to DROP with no err. Non-event packets are silently discarded.
  - If subtype is 0, set expected word count to NW.
  - If subtype is 1, set expected word count to 1.
  - If subtype is any other value, go to DROP and pulse err.
  - Otherwise clear the word index and go to PAYLOAD.
- PAYLOAD, on an accepted flit:
  - Write data into bits [16*idx +: 16] of the assembly register and increment idx.
  - If idx+1 == expected and last, go to OUT.
  - If last arrives early, pulse err and go to DEST. The partial sample is discarded.
  - If idx+1 == expected and !last, pulse err and go to DROP (too long).
- In the final payload word, bits beyond WIDTH are discarded.
- DROP: accept flits until one with last is accepted, then go to DEST.
- OUT: trace_valid = 1. On trace_ready, go to DEST.
- debug_in_ready = 1 in every state except OUT, where it is 0 (backpressure onto the ring).
- The assembly register is not cleared between packets. Every bit in [WIDTH-1:0] is overwritten before OUT is reached. For overflow records, bits [WIDTH-1:16] are forced to 0 on entry to OUT.

## Timing
- Reset values:
  - trace_valid = 0, trace_overflow = 0, trace_data = 0, trace_src = 0, err = 0.
  - debug_in_ready = 1 in DEST.
- Latency: trace_valid rises in the cycle after the last payload flit is accepted.
- trace_data, trace_overflow and trace_src are registered and stable while trace_valid is high.
- After a record is taken (trace_valid && trace_ready), trace_valid is 0 in the next cycle, and debug_in_ready is 1 in that same next cycle.
- Throughput: one flit per cycle; a packet of 3+NW flits plus one OUT cycle when trace_ready is held high.
- err is registered and asserts in the cycle after the offending flit.
- Asynchronous reset mid-packet returns the block to DEST immediately. The remaining flits of the interrupted packet are then parsed as a new packet, and the resulting err pulse is acceptable.
- Flits with valid = 0 never advance state, in any state.

## Test plan
- WIDTH = 40, id = 16'h0005. Send [0005, 0010, 8000, AAAA, BBBB, 00CC(last)] -> trace_valid with data 40'hCC_BBBB_AAAA, src 16'h0010, overflow 0, err never asserted.
- Overflow packet [0005, 0010, 8400, 0007(last)] -> trace_overflow = 1, trace_data = 40'h7.
- Destination 16'h0006, then a good packet back-to-back -> the first packet is fully consumed with no output and no err; the second is produced normally.
- Malformed packets:
  - Short payload [0005, 0010, 8000, AAAA(last)] -> err pulse, no trace_valid.
  - Long payload (4 payload words) -> err pulse, remainder dropped, no trace_valid.
- Hold trace_ready = 0 for 10 cycles while in OUT -> debug_in_ready stays 0 and the output stays stable. Release -> the next packet is accepted starting the following cycle.
- Assert rst low after the header flit, release it, then send a fresh good packet -> all outputs return to reset values during reset, and the fresh packet is output correctly.
